// File: rtl/sr_cmd_debounce.sv
// Command front end for an SR flop: synchronises and debounces the set/clear
// buttons, edge-detects presses and issues single-cycle exclusive s/r pulses.
module sr_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 3,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       clr_btn,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic       suppressed,
    output logic       dropped,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE_S = 2'd1;
    localparam logic [1:0] ISSUE_R = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    // Channel 0 is the set button, channel 1 the clear button.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       press;
    logic [CNT_W-1:0] db_cnt [2];

    logic [1:0]       state;
    logic [CNT_W-1:0] gap_cnt;

    assign btn_raw = {clr_btn, set_btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_db
        always_ff @(posedge clk) begin
            if (rst) begin
                stable[ch] <= 1'b0;
                db_cnt[ch] <= '0;
            end else if (sync2[ch] == stable[ch]) begin
                db_cnt[ch] <= '0;
            end else if (db_cnt[ch] == DB_LAST) begin
                stable[ch] <= sync2[ch];
                db_cnt[ch] <= '0;
            end else begin
                db_cnt[ch] <= db_cnt[ch] + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            conflict   <= 1'b0;
            suppressed <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            conflict   <= 1'b0;
            suppressed <= 1'b0;
            dropped    <= 1'b0;
            case (state)
                IDLE: begin
                    // A double press is a conflict regardless of q_fb.
                    if (press == 2'b11) begin
                        conflict <= 1'b1;
                    end else if (press[0]) begin
                        if (q_fb) suppressed <= 1'b1;
                        else      state      <= ISSUE_S;
                    end else if (press[1]) begin
                        if (!q_fb) suppressed <= 1'b1;
                        else       state      <= ISSUE_R;
                    end
                end
                ISSUE_S, ISSUE_R: begin
                    dropped <= |press;
                    gap_cnt <= '0;
                    state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                default: begin
                    dropped <= |press;
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign s         = (state == ISSUE_S);
    assign r         = (state == ISSUE_R);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce (DEBOUNCE_CYCLES=4, GAP_CYCLES=3):
// exact pulse timing, bounce rejection, conflict, suppression, lockout, reset.
module tb_sr_cmd_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_btn;
    logic       clr_btn;
    logic       q_fb;
    logic       s;
    logic       r;
    logic       busy;
    logic       conflict;
    logic       suppressed;
    logic       dropped;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse counters sampled at the falling edge, away from the active edge.
    int cnt_s = 0, cnt_r = 0, cnt_conf = 0, cnt_supp = 0, cnt_drop = 0;
    int inv_bad = 0;

    sr_cmd_debounce #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (3),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_btn   (set_btn),
        .clr_btn   (clr_btn),
        .q_fb      (q_fb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .conflict  (conflict),
        .suppressed(suppressed),
        .dropped   (dropped),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s)          cnt_s++;
        if (r)          cnt_r++;
        if (conflict)   cnt_conf++;
        if (suppressed) cnt_supp++;
        if (dropped)    cnt_drop++;
        if (s && r) inv_bad++;
        if ((int'(conflict) + int'(suppressed) + int'(dropped)) > 1) inv_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n active edges; sampling and driving happen 1ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int b_s, b_r, b_conf, b_supp, b_drop;

    task automatic mark();
        b_s = cnt_s; b_r = cnt_r; b_conf = cnt_conf; b_supp = cnt_supp; b_drop = cnt_drop;
    endtask

    task automatic quiet_wait();
        set_btn = 1'b0;
        clr_btn = 1'b0;
        tick(14);
    endtask

    initial begin
        rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0; q_fb = 1'b0;
        tick(3);
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        check("rst_flags", {conflict, suppressed, dropped}, 0);
        rst = 1'b0;
        tick(2);

        // Clean set press: s exactly E6..E7, busy E6..E10.
        mark();
        set_btn = 1'b1;
        tick(6);
        check("clean_s_before", s, 0);
        tick(1);
        check("clean_s_at_e6", s, 1);
        check("clean_r_at_e6", r, 0);
        check("clean_busy_e6", busy, 1);
        tick(1);
        check("clean_s_e7", s, 0);
        check("clean_state_gap", state_dbg, 3);
        tick(2);
        check("clean_busy_e9", busy, 1);
        tick(1);
        check("clean_busy_e10", busy, 0);
        q_fb = 1'b1;
        quiet_wait();
        check("clean_s_count", cnt_s - b_s, 1);
        check("clean_r_count", cnt_r - b_r, 0);

        // Bounce shorter than the debounce window never lands.
        q_fb = 1'b0;
        mark();
        set_btn = 1'b1; tick(1);
        set_btn = 1'b0; tick(1);
        set_btn = 1'b1; tick(1);
        set_btn = 1'b0; tick(1);
        tick(12);
        check("bounce_stable", dut.stable[0], 0);
        check("bounce_s_count", cnt_s - b_s, 0);
        check("bounce_flags", (cnt_conf - b_conf) + (cnt_supp - b_supp) + (cnt_drop - b_drop), 0);

        // Simultaneous presses.
        mark();
        set_btn = 1'b1; clr_btn = 1'b1;
        tick(7);
        check("conf_pulse", conflict, 1);
        check("conf_busy", busy, 0);
        check("conf_sr", {s, r}, 0);
        tick(1);
        check("conf_one_cycle", conflict, 0);
        quiet_wait();
        check("conf_count", cnt_conf - b_conf, 1);
        check("conf_sr_count", (cnt_s - b_s) + (cnt_r - b_r), 0);

        // Redundant set with q_fb=1, then a real clear.
        q_fb = 1'b1;
        mark();
        set_btn = 1'b1;
        tick(7);
        check("supp_pulse", suppressed, 1);
        check("supp_busy", busy, 0);
        quiet_wait();
        check("supp_count", cnt_supp - b_supp, 1);
        check("supp_s_count", cnt_s - b_s, 0);
        mark();
        clr_btn = 1'b1;
        tick(7);
        check("clr_r_pulse", r, 1);
        q_fb = 1'b0;
        quiet_wait();
        check("clr_r_count", cnt_r - b_r, 1);

        // Lockout: clear press lands in GAP and is dropped.
        mark();
        set_btn = 1'b1;
        tick(2);
        clr_btn = 1'b1;
        tick(5);
        check("lock_s", s, 1);
        q_fb = 1'b1;
        tick(2);
        check("lock_drop", dropped, 1);
        check("lock_r", r, 0);
        quiet_wait();
        check("lock_drop_count", cnt_drop - b_drop, 1);
        check("lock_r_count", cnt_r - b_r, 0);
        mark();
        clr_btn = 1'b1;
        tick(7);
        check("lock_retry_r", r, 1);
        q_fb = 1'b0;
        quiet_wait();
        check("lock_retry_count", cnt_r - b_r, 1);

        // Reset at the edge that would enter GAP.
        set_btn = 1'b1;
        tick(7);
        check("mid_s", s, 1);
        rst = 1'b1;
        tick(1);
        check("mid_busy", busy, 0);
        check("mid_sr", {s, r}, 0);
        check("mid_state", state_dbg, 0);
        check("mid_stable", dut.stable, 0);
        check("mid_sync", {dut.sync1, dut.sync2}, 0);
        check("mid_db_cnt", {dut.db_cnt[0], dut.db_cnt[1]}, 0);
        check("mid_gap_cnt", dut.gap_cnt, 0);
        rst = 1'b0;
        quiet_wait();

        check("invariants", inv_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
